// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master AHB arbiter; HCLK/HRESETn (sync, active-low), HREADY, per-master hbusreq/haddr/htrans/hwdata in; HGRANT0/1, HMASTER, muxed HADDR/HTRANS/HWDATA out; tenure-limited hand-over, parks on master 0
module ahb_arbiter #(
  parameter int ADDRWIDTH   = 32,
  parameter int DATAWIDTH   = 32,
  parameter int Trans_Width = 2,
  parameter int MAXHOLD     = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HREADY,
  input  logic                   m0_hbusreq,
  input  logic                   m1_hbusreq,
  input  logic [ADDRWIDTH-1:0]   m0_haddr,
  input  logic [ADDRWIDTH-1:0]   m1_haddr,
  input  logic [Trans_Width-1:0] m0_htrans,
  input  logic [Trans_Width-1:0] m1_htrans,
  input  logic [DATAWIDTH-1:0]   m0_hwdata,
  input  logic [DATAWIDTH-1:0]   m1_hwdata,
  output logic                   HGRANT0,
  output logic                   HGRANT1,
  output logic                   HMASTER,
  output logic [ADDRWIDTH-1:0]   HADDR,
  output logic [Trans_Width-1:0] HTRANS,
  output logic [DATAWIDTH-1:0]   HWDATA
);
  typedef enum logic {OWN0, OWN1} state_t;
  localparam logic [7:0] HOLD = 8'(MAXHOLD);
  localparam logic [Trans_Width-1:0] BUSY = Trans_Width'(1);
  localparam logic [Trans_Width-1:0] NONSEQ = Trans_Width'(2);
  localparam logic [Trans_Width-1:0] SEQ = Trans_Width'(3);
  state_t state, state_nx;
  logic dmaster, own_req, oth_req, arb, acc;
  logic [7:0] tenure;
  assign HMASTER = state == OWN1;
  assign HGRANT0 = !HMASTER;
  assign HGRANT1 = HMASTER;
  assign HADDR = HMASTER ? m1_haddr : m0_haddr;
  assign HTRANS = HMASTER ? m1_htrans : m0_htrans;
  assign HWDATA = dmaster ? m1_hwdata : m0_hwdata;
  assign own_req = HMASTER ? m1_hbusreq : m0_hbusreq;
  assign oth_req = HMASTER ? m0_hbusreq : m1_hbusreq;
  assign arb = HREADY && HTRANS != BUSY;
  assign acc = HREADY && (HTRANS == NONSEQ || HTRANS == SEQ);
  always_comb begin
    state_nx = state;
    if (arb && !own_req && !oth_req) state_nx = OWN0;
    else if (arb && oth_req && (!own_req || tenure == HOLD)) state_nx = HMASTER ? OWN0 : OWN1;
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= OWN0;
      dmaster <= 1'b0;
      tenure <= '0;
    end else begin
      state <= state_nx;
      if (HREADY) dmaster <= HMASTER;
      if (state_nx != state || !own_req) tenure <= '0;
      else if (acc && tenure != HOLD) tenure <= tenure + 8'd1;
    end
  end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed bench for ahb_arbiter with a per-cycle reference model and literal checkpoints
module tb_ahb_arbiter;
  localparam int AW = 32, DW = 32, TW = 2, MH = 8;
  logic clk = 0, rstn = 0, ready = 1, r0 = 0, r1 = 0;
  logic [AW-1:0] a0 = 32'h0000_A000, a1 = 32'h0000_B000;
  logic [TW-1:0] t0 = 0, t1 = 0;
  logic [DW-1:0] d0 = 32'hD000_0000, d1 = 32'hE000_0000;
  logic g0, g1, hm;
  logic [AW-1:0] haddr;
  logic [TW-1:0] htrans;
  logic [DW-1:0] hwdata;
  int passed = 0, total = 0;
  int m_own = 0, m_dm = 0, m_ten = 0;
  bit m_valid = 0;
  always #5 clk = ~clk;
  ahb_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .Trans_Width(TW), .MAXHOLD(MH)) dut (
    .HCLK(clk), .HRESETn(rstn), .HREADY(ready),
    .m0_hbusreq(r0), .m1_hbusreq(r1),
    .m0_haddr(a0), .m1_haddr(a1),
    .m0_htrans(t0), .m1_htrans(t1),
    .m0_hwdata(d0), .m1_hwdata(d1),
    .HGRANT0(g0), .HGRANT1(g1), .HMASTER(hm),
    .HADDR(haddr), .HTRANS(htrans), .HWDATA(hwdata)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  always @(posedge clk) begin : mdl
    int own_req, oth_req, tr, nxt;
    if (!rstn) begin
      m_own <= 0;
      m_dm <= 0;
      m_ten <= 0;
      m_valid <= 1;
    end else begin
      own_req = m_own ? int'(r1) : int'(r0);
      oth_req = m_own ? int'(r0) : int'(r1);
      tr = m_own ? int'(t1) : int'(t0);
      nxt = m_own;
      if (ready && tr != 1) begin
        if (!r0 && !r1) nxt = 0;
        else if (oth_req != 0 && (own_req == 0 || m_ten >= MH)) nxt = 1 - m_own;
      end
      if (ready) m_dm <= m_own;
      m_ten <= (nxt != m_own || own_req == 0) ? 0 : (ready && tr >= 2) ? ((m_ten + 1 > MH) ? MH : m_ten + 1) : m_ten;
      m_own <= nxt;
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      chk("grant0", 64'(g0), 64'(m_own == 0));
      chk("grant1", 64'(g1), 64'(m_own == 1));
      chk("hmaster", 64'(hm), 64'(m_own));
      chk("haddr", 64'(haddr), 64'(m_own != 0 ? a1 : a0));
      chk("htrans", 64'(htrans), 64'(m_own != 0 ? t1 : t0));
      chk("hwdata", 64'(hwdata), 64'(m_dm != 0 ? d1 : d0));
    end
  end
  initial begin
    tick(2);
    chk("rst_g0", 64'(g0), 64'd1);
    chk("rst_g1", 64'(g1), 64'd0);
    chk("rst_hm", 64'(hm), 64'd0);
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      t0 = TW'(i);
      tick();
      chk("idle_hm", 64'(hm), 64'd0);
      chk("idle_htrans", 64'(htrans), 64'(i));
    end
    t0 = 0;
    r1 = 1;
    t1 = 2;
    tick();
    chk("req1_hm", 64'(hm), 64'd1);
    chk("req1_g1", 64'(g1), 64'd1);
    chk("req1_haddr", 64'(haddr), 64'h0000_B000);
    chk("req1_hwdata_old", 64'(hwdata), 64'hD000_0000);
    tick();
    chk("req1_hwdata_new", 64'(hwdata), 64'hE000_0000);
    r1 = 0;
    tick();
    chk("park_hm", 64'(hm), 64'd0);
    r0 = 1;
    r1 = 1;
    t0 = 2;
    t1 = 3;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hold0_hm", 64'(hm), 64'd0);
    end
    tick();
    chk("swap01_hm", 64'(hm), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hold1_hm", 64'(hm), 64'd1);
    end
    tick();
    chk("swap10_hm", 64'(hm), 64'd0);
    tick(8);
    chk("full0_hm", 64'(hm), 64'd0);
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hm", 64'(hm), 64'd0);
      chk("stall_hwdata", 64'(hwdata), 64'hD000_0000);
    end
    ready = 1;
    tick();
    chk("handover_hm", 64'(hm), 64'd1);
    chk("handover_hwdata_old", 64'(hwdata), 64'hD000_0000);
    tick();
    chk("handover_hwdata_new", 64'(hwdata), 64'hE000_0000);
    tick(7);
    chk("full1_hm", 64'(hm), 64'd1);
    t1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_hm", 64'(hm), 64'd1);
    end
    t1 = 3;
    tick();
    chk("unbusy_hm", 64'(hm), 64'd0);
    r0 = 0;
    r1 = 1;
    tick();
    chk("yield_hm", 64'(hm), 64'd1);
    tick();
    chk("yield_hwdata", 64'(hwdata), 64'hE000_0000);
    ready = 0;
    rstn = 0;
    tick();
    chk("midrst_g0", 64'(g0), 64'd1);
    chk("midrst_hm", 64'(hm), 64'd0);
    chk("midrst_hwdata", 64'(hwdata), 64'hD000_0000);
    rstn = 1;
    ready = 1;
    r1 = 0;
    tick();
    chk("post_rst_hm", 64'(hm), 64'd0);
    for (int i = 0; i < 80; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      ready = $urandom_range(0, 3) != 0;
      t0 = TW'($urandom_range(0, 3));
      t1 = TW'($urandom_range(0, 3));
      a0 = $urandom;
      a1 = $urandom;
      d0 = $urandom;
      d1 = $urandom;
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter ADDRWIDTH, default 32: width of HADDR and the per-master address inputs.
REQ-002 Parameter DATAWIDTH, default 32: width of HWDATA and the per-master write-data inputs.
REQ-003 Parameter Trans_Width, default 2: width of HTRANS and the per-master transfer-type inputs.
REQ-004 Parameter MAXHOLD, default 8, range 1..255: number of accepted transfers an owner may make before it yields to a waiting requester.
REQ-005 HCLK  input  1: the single clock; all state SHALL update on the HCLK rising edge.
REQ-006 HRESETn  input  1: reset, synchronous and active-low.
REQ-007 HREADY  input  1: transfer-complete indication from the slave side.
REQ-008 m0_hbusreq, m1_hbusreq  input  1 each: bus request from master 0 and master 1.
REQ-009 m0_haddr, m1_haddr  input  ADDRWIDTH each: address driven by each master.
REQ-010 m0_htrans, m1_htrans  input  Trans_Width each: transfer type driven by each master (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-011 m0_hwdata, m1_hwdata  input  DATAWIDTH each: write data driven by each master.
REQ-012 HGRANT0, HGRANT1  output  1 each: registered grant; exactly one SHALL be high at all times.
REQ-013 HMASTER  output  1: current address-phase owner.
REQ-014 HADDR  output  ADDRWIDTH: muxed address.
REQ-015 HTRANS  output  Trans_Width: muxed transfer type.
REQ-016 HWDATA  output  DATAWIDTH: muxed write data.

Function
REQ-017 Owner FSM states SHALL be OWN0 and OWN1; HMASTER=0 in OWN0 and 1 in OWN1; HGRANTx = (HMASTER==x).
REQ-018 The data-phase owner register dmaster SHALL load HMASTER on every edge with HREADY=1 and hold its value when HREADY=0.
REQ-019 HADDR and HTRANS SHALL select the owner's m*_haddr/m*_htrans combinationally by HMASTER, with zero cycles of added latency.
REQ-020 HWDATA SHALL select m*_hwdata by dmaster.
REQ-021 The tenure counter (8 bit) SHALL increment on each edge with HREADY=1 and owner HTRANS in {NONSEQ, SEQ}, saturating at MAXHOLD.
REQ-022 An arbitration point SHALL be an edge with HREADY=1 and owner HTRANS != BUSY; no ownership change SHALL occur at any other edge.
REQ-023 At an arbitration point the FSM SHALL switch to the other master iff that master's hbusreq=1 and either the owner's hbusreq=0 or tenure==MAXHOLD.
REQ-024 At an arbitration point with both hbusreq=0, the FSM SHALL go to OWN0 (park on master 0).
REQ-025 The tenure counter SHALL clear to 0 on every ownership change and on every edge where the owner's hbusreq=0.
REQ-026 The new grant SHALL be visible one cycle after the arbitration-point edge, so HADDR/HTRANS follow the new owner from that cycle.
REQ-027 Data-phase HWDATA of the old owner SHALL remain selected until HREADY=1 completes its outstanding transfer.
REQ-028 If both masters request simultaneously with no owner tenure pending, the current owner SHALL keep the bus until REQ-023 fires; no fixed priority applies other than parking.
REQ-029 A burst cut by a grant loss is legal; the block SHALL NOT track bursts, and a master restarts with NONSEQ.

Reset
REQ-030 While HRESETn=0 at an edge: FSM=OWN0, HGRANT0=1, HGRANT1=0, HMASTER=0, dmaster=0, tenure=0.
REQ-031 Reset asserted mid-transfer SHALL override HREADY and requests on that edge, with no partial state retained.

Verification
REQ-032 Reset release with no requests -> HGRANT0=1, HMASTER=0, HTRANS equals m0_htrans every cycle.
REQ-033 m1_hbusreq=1 while m0 idle (m0_hbusreq=0, HREADY=1) -> HGRANT1=1 on the next cycle; HWDATA switches to m1 one HREADY-cycle later.
REQ-034 Both request; m0 owns with continuous NONSEQ/SEQ, MAXHOLD=8, HREADY=1 -> grant moves to m1 after the 8th accepted m0 transfer, then back to m0 after 8 m1 transfers.
REQ-035 At the hand-over edge, HREADY held 0 for 3 cycles -> no grant change and dmaster/HWDATA stay on the old owner until HREADY=1.
REQ-036 Owner HTRANS=BUSY with HREADY=1 and other requesting at MAXHOLD -> no switch until HTRANS leaves BUSY.
REQ-037 HRESETn pulled low while OWN1 with HREADY=0 -> next cycle HGRANT0=1, HMASTER=0, dmaster=0, tenure=0.
